// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared funct3 codes, FSM state type and access-legality helpers for the LSU
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic logic is_valid_funct3(input logic we, input logic [2:0] f3);
    logic ok;
    ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    if (!we) begin
      ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
    end
    return ok;
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic mis;
    case (f3)
      F3_H, F3_HU: mis = off[0];
      F3_W:        mis = (off != 2'b00);
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - store lane strobes/replication and load byte/half extraction with extension
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  st_funct3_i,
  input  logic [1:0]  st_off_i,
  input  logic [31:0] st_data_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  input  logic [2:0]  ld_funct3_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] ld_word_i,
  output logic [31:0] ld_data_o
);

  logic [31:0] byte_sh;
  logic [31:0] half_sh;

  // Misaligned halfwords fall back to the enclosing aligned half; words ignore the offset.
  always_comb begin
    wstrb_o = 4'b0000;
    wdata_o = st_data_i;
    case (st_funct3_i)
      F3_B: begin
        wstrb_o = 4'b0001 << st_off_i;
        wdata_o = {4{st_data_i[7:0]}};
      end
      F3_H: begin
        wstrb_o = 4'b0011 << {st_off_i[1], 1'b0};
        wdata_o = {2{st_data_i[15:0]}};
      end
      F3_W: begin
        wstrb_o = 4'b1111;
      end
      default: begin
        wstrb_o = 4'b0000;
      end
    endcase
  end

  always_comb begin
    byte_sh   = ld_word_i >> {ld_off_i, 3'b000};
    half_sh   = ld_word_i >> {ld_off_i[1], 4'b0000};
    ld_data_o = ld_word_i;
    case (ld_funct3_i)
      F3_B:    ld_data_o = {{24{byte_sh[7]}}, byte_sh[7:0]};
      F3_BU:   ld_data_o = {24'h000000, byte_sh[7:0]};
      F3_H:    ld_data_o = {{16{half_sh[15]}}, half_sh[15:0]};
      F3_HU:   ld_data_o = {16'h0000, half_sh[15:0]};
      default: ld_data_o = ld_word_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store unit; MISALIGN_TRAP_EN makes misaligned accesses raise err
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [4:0]      req_rd,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_wstrb,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            err
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [2:0]      f3_q, f3_d;
  logic [1:0]      off_q, off_d;
  logic [4:0]      rd_q, rd_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]      mem_wstrb_q, mem_wstrb_d;
  logic            wb_valid_q, wb_valid_d;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic            err_q, err_d;
  logic            req_bad;

  logic [3:0]      al_wstrb;
  logic [XLEN-1:0] al_wdata;
  logic [XLEN-1:0] al_ld_data;

  lsu_align u_align (
    .st_funct3_i (req_funct3),
    .st_off_i    (req_addr[1:0]),
    .st_data_i   (req_wdata),
    .wstrb_o     (al_wstrb),
    .wdata_o     (al_wdata),
    .ld_funct3_i (f3_q),
    .ld_off_i    (off_q),
    .ld_word_i   (mem_rdata),
    .ld_data_o   (al_ld_data)
  );

  assign req_ready = (state_q == IDLE) && !rst;

`ifdef MISALIGN_TRAP_EN
  assign req_bad = !is_valid_funct3(req_we, req_funct3) ||
                   is_misaligned(req_funct3, req_addr[1:0]);
`else
  assign req_bad = !is_valid_funct3(req_we, req_funct3);
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    f3_d        = f3_q;
    off_d       = off_q;
    rd_d        = rd_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    wb_valid_d  = 1'b0;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    err_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          cnt_d = '0;
          we_d  = req_we;
          f3_d  = req_funct3;
          off_d = req_addr[1:0];
          rd_d  = req_rd;
          if (req_bad) begin
            err_d = 1'b1;
          end else begin
            state_d     = REQ;
            mem_req_d   = 1'b1;
            mem_we_d    = req_we;
            mem_addr_d  = {req_addr[XLEN-1:2], 2'b00};
            mem_wdata_d = req_we ? al_wdata : '0;
            mem_wstrb_d = req_we ? al_wstrb : 4'b0000;
          end
        end
      end
      REQ: begin
        if (mem_ack) begin
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_wstrb_d = 4'b0000;
          if (we_q) begin
            state_d = IDLE;
          end else begin
            state_d    = RESP;
            wb_valid_d = 1'b1;
            wb_rd_d    = rd_q;
            wb_data_d  = al_ld_data;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
          // Abort once the REQ phase has lasted MEM_TIMEOUT cycles without an ack.
          if (cnt_d == CW'(MEM_TIMEOUT)) begin
            state_d     = IDLE;
            mem_req_d   = 1'b0;
            mem_we_d    = 1'b0;
            mem_wstrb_d = 4'b0000;
            err_d       = 1'b1;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      f3_q        <= 3'b000;
      off_q       <= 2'b00;
      rd_q        <= 5'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= 4'b0000;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= 5'd0;
      wb_data_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
      rd_q        <= rd_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      wb_valid_q  <= wb_valid_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      err_q       <= err_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  assign wb_valid  = wb_valid_q;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;
  assign err       = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  load_store_unit #(.XLEN(32), .MEM_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .err(err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one access and returns in cycle N+1 (one step after acceptance).
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [4:0] rd);
    int k = 0;
    while (!req_ready && k < 50) begin
      step();
      k++;
    end
    tests++;
    if (!req_ready) begin
      fails++;
      $display("FAIL issue_ready: req_ready=%0b after %0d cycles, required 1", req_ready, k);
    end
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    req_rd     = rd;
    step();
    req_valid  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    tests++;
    if (req_ready !== 1'b0) begin fails++; $display("FAIL rst_ready: got %0b want 0", req_ready); end
    tests++;
    if ({mem_req, mem_we, wb_valid, err} !== 4'b0000) begin
      fails++; $display("FAIL rst_ctrl: got %b want 0000", {mem_req, mem_we, wb_valid, err});
    end
    tests++;
    if ({mem_addr, mem_wdata, wb_data, mem_wstrb, wb_rd} !== 105'd0) begin
      fails++; $display("FAIL rst_data: addr=%h wdata=%h wb=%h strb=%b rd=%0d want all 0",
                        mem_addr, mem_wdata, wb_data, mem_wstrb, wb_rd);
    end
    rst = 1'b0;
    #1;
    tests++;
    if (req_ready !== 1'b1) begin fails++; $display("FAIL rst_release_ready: got %0b want 1", req_ready); end
  endtask

  task automatic test_store_word();
    issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 5'd0);
    tests++;
    if ({mem_req, mem_we, mem_wstrb} !== 6'b11_1111) begin
      fails++; $display("FAIL sw_ctrl: req/we/strb=%b want 111111", {mem_req, mem_we, mem_wstrb});
    end
    tests++;
    if (mem_addr !== 32'h10 || mem_wdata !== 32'hDEADBEEF) begin
      fails++; $display("FAIL sw_bus: addr=%h data=%h want 00000010 deadbeef", mem_addr, mem_wdata);
    end
    tests++;
    if (req_ready !== 1'b0) begin fails++; $display("FAIL sw_busy: req_ready=%0b want 0", req_ready); end
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    tests++;
    if ({mem_req, req_ready, wb_valid, err} !== 4'b0100) begin
      fails++; $display("FAIL sw_done: req/ready/wb/err=%b want 0100", {mem_req, req_ready, wb_valid, err});
    end
  endtask

  task automatic load_check(input string name, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] word, input logic [4:0] rd, input logic [31:0] exp);
    issue(1'b0, f3, addr, 32'h0, rd);
    tests++;
    if ({mem_req, mem_we, mem_wstrb} !== 6'b10_0000 || mem_addr !== {addr[31:2], 2'b00}) begin
      fails++; $display("FAIL %s_req: req/we/strb=%b addr=%h want 100000 %h",
                        name, {mem_req, mem_we, mem_wstrb}, mem_addr, {addr[31:2], 2'b00});
    end
    mem_ack   = 1'b1;
    mem_rdata = word;
    step();
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    tests++;
    if (wb_valid !== 1'b1 || wb_data !== exp || wb_rd !== rd) begin
      fails++; $display("FAIL %s_wb: valid=%0b data=%h rd=%0d want 1 %h %0d", name, wb_valid, wb_data, wb_rd, exp, rd);
    end
    tests++;
    if (req_ready !== 1'b0 || mem_req !== 1'b0) begin
      fails++; $display("FAIL %s_resp: ready=%0b req=%0b want 0 0", name, req_ready, mem_req);
    end
    step();
    tests++;
    if (wb_valid !== 1'b0 || req_ready !== 1'b1) begin
      fails++; $display("FAIL %s_after: valid=%0b ready=%0b want 0 1", name, wb_valid, req_ready);
    end
  endtask

  task automatic test_loads();
    logic [31:0] word;
    issue(1'b1, 3'b010, 32'h20, 32'h80FF7F01, 5'd0);
    tests++;
    if (mem_wdata !== 32'h80FF7F01 || mem_wstrb !== 4'b1111) begin
      fails++; $display("FAIL ld_prestore: data=%h strb=%b want 80ff7f01 1111", mem_wdata, mem_wstrb);
    end
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    word = 32'h80FF7F01;
    load_check("lb3",  3'b000, 32'h23, word, 5'd5,  32'hFFFFFF80);
    load_check("lbu1", 3'b100, 32'h21, word, 5'd6,  32'h0000007F);
    load_check("lh2",  3'b001, 32'h22, word, 5'd7,  32'hFFFF80FF);
    load_check("lhu0", 3'b101, 32'h20, word, 5'd8,  32'h00007F01);
    load_check("lw_x0", 3'b010, 32'h20, word, 5'd0, 32'h80FF7F01);
  endtask

  task automatic test_sub_stores();
    issue(1'b1, 3'b000, 32'h22, 32'h123456AB, 5'd0);
    tests++;
    if (mem_wstrb !== 4'b0100 || mem_wdata !== 32'hABABABAB || mem_addr !== 32'h20) begin
      fails++; $display("FAIL sb: strb=%b data=%h addr=%h want 0100 abababab 00000020", mem_wstrb, mem_wdata, mem_addr);
    end
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    issue(1'b1, 3'b001, 32'h22, 32'h9999BEEF, 5'd0);
    tests++;
    if (mem_wstrb !== 4'b1100 || mem_wdata !== 32'hBEEFBEEF) begin
      fails++; $display("FAIL sh: strb=%b data=%h want 1100 beefbeef", mem_wstrb, mem_wdata);
    end
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
  endtask

  task automatic test_timeout();
    int cyc = 0;
    int wbs = 0;
    issue(1'b0, 3'b010, 32'h40, 32'h0, 5'd3);
    while (mem_req && cyc < 40) begin
      if (err) cyc = cyc + 100;
      cyc++;
      step();
      if (wb_valid) wbs++;
    end
    tests++;
    if (cyc !== 16) begin fails++; $display("FAIL to_cycles: req cycles=%0d want 16", cyc); end
    tests++;
    if ({err, mem_req, req_ready, wb_valid} !== 4'b1010 || wbs !== 0) begin
      fails++; $display("FAIL to_abort: err/req/ready/wb=%b wbs=%0d want 1010 0", {err, mem_req, req_ready, wb_valid}, wbs);
    end
    step();
    tests++;
    if (err !== 1'b0 || wb_valid !== 1'b0) begin fails++; $display("FAIL to_pulse: err=%0b wb=%0b want 0 0", err, wb_valid); end
  endtask

  task automatic test_illegal();
    int seen = 0;
    issue(1'b0, 3'b011, 32'h50, 32'h0, 5'd4);
    tests++;
    if ({err, mem_req, req_ready} !== 3'b101) begin
      fails++; $display("FAIL bad_ld: err/req/ready=%b want 101", {err, mem_req, req_ready});
    end
    for (int i = 0; i < 3; i++) begin
      step();
      if (mem_req || err) seen++;
    end
    tests++;
    if (seen !== 0) begin fails++; $display("FAIL bad_ld_quiet: %0d cycles with req/err, want 0", seen); end
    issue(1'b1, 3'b100, 32'h50, 32'h0, 5'd0);
    tests++;
    if ({err, mem_req} !== 2'b10) begin fails++; $display("FAIL bad_st: err/req=%b want 10", {err, mem_req}); end
    step();
`ifdef MISALIGN_TRAP_EN
    issue(1'b0, 3'b010, 32'h13, 32'h0, 5'd9);
    tests++;
    if ({err, mem_req, req_ready} !== 3'b101) begin
      fails++; $display("FAIL mis_lw: err/req/ready=%b want 101", {err, mem_req, req_ready});
    end
    step();
    tests++;
    if (wb_valid !== 1'b0 || mem_req !== 1'b0) begin fails++; $display("FAIL mis_lw_quiet: wb=%0b req=%0b want 0 0", wb_valid, mem_req); end
`else
    load_check("mis_lw", 3'b010, 32'h13, 32'hCAFEF00D, 5'd9, 32'hCAFEF00D);
    load_check("mis_lh", 3'b001, 32'h13, 32'hCAFEF00D, 5'd9, 32'hFFFFCAFE);
`endif
  endtask

  task automatic test_reset_mid();
    issue(1'b0, 3'b010, 32'h60, 32'h0, 5'd2);
    tests++;
    if (mem_req !== 1'b1) begin fails++; $display("FAIL rm_req: mem_req=%0b want 1", mem_req); end
    rst = 1'b1;
    step();
    tests++;
    if (mem_req !== 1'b0 || req_ready !== 1'b0) begin
      fails++; $display("FAIL rm_abort: req=%0b ready=%0b want 0 0", mem_req, req_ready);
    end
    rst = 1'b0;
    #1;
    tests++;
    if (req_ready !== 1'b1) begin fails++; $display("FAIL rm_ready: got %0b want 1", req_ready); end
    mem_ack   = 1'b1;
    mem_rdata = 32'h55AA55AA;
    step();
    mem_ack   = 1'b0;
    tests++;
    if ({wb_valid, mem_req, err, req_ready} !== 4'b0001) begin
      fails++; $display("FAIL rm_late_ack: wb/req/err/ready=%b want 0001", {wb_valid, mem_req, err, req_ready});
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0;
    mem_ack = 1'b0; mem_rdata = 32'h0;
    test_reset();
    test_store_word();
    test_loads();
    test_sub_stores();
    test_timeout();
    test_illegal();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
